// File: rtl/if_id_fetch_buffer.sv
// ---------------------------------------------------------------------------
// if_id_fetch_buffer
//
// Sits between the IF pc generator and the decode stage. It issues fetches to
// a synchronous instruction memory (1-cycle read latency), parks returning
// words in a small skid FIFO while decode is stalled, and drives the
// registered IF/ID pipeline register (pc, instr, valid, misalign) into ID.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   if_pc, if_ce  fetch address and fetch request from IF
//   req_accept    fetch of if_pc issued this cycle (IF holds if_pc while 0)
//   imem_en       instruction memory read enable
//   imem_addr     instruction memory byte address
//   imem_rdata    read data, valid the cycle after imem_en
//   id_stall      decode cannot accept; IF/ID register holds
//   id_flush      redirect; drop every older fetch and insert a NOP
//   id_pc         IF/ID pc
//   id_instr      IF/ID instruction word (NOP_INSTR on bubbles)
//   id_valid      IF/ID holds a real instruction
//   id_misalign   IF/ID pc had nonzero low bits
//   fifo_count    skid FIFO occupancy (debug)
// ---------------------------------------------------------------------------
module if_id_fetch_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                if_pc,
  input  logic                       if_ce,
  output logic                       req_accept,
  output logic                       imem_en,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       id_stall,
  input  logic                       id_flush,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_instr,
  output logic                       id_valid,
  output logic                       id_misalign,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic              inflight;
  logic [31:0]       inflight_pc;
  logic              kill;
  logic              resp_valid;
  logic [CW:0]       occupancy;
  logic              issue;

  logic [31:0]       fifo_pc    [DEPTH];
  logic [31:0]       fifo_instr [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic              push;
  logic              pop;
  logic              load_fifo;
  logic              load_bypass;
  logic              clear;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit check counts the buffered words plus the one fetch whose data is
  // still on its way, so a response always has a FIFO slot to land in even
  // if decode stalls. A pop in the same cycle earns no credit, which keeps
  // the gate free of any dependency on id_stall.
  assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign issue      = rst_n & if_ce & (occupancy < (CW+1)'(DEPTH));
  assign req_accept = issue;
  assign imem_en    = issue;
  assign imem_addr  = if_pc;

  assign resp_valid = inflight & ~kill;

  // One decision per cycle about where a returning word goes and what the
  // IF/ID register loads. Flush outranks stall, so a stalled decode that
  // gets redirected still empties the FIFO.
  always_comb begin
    push        = 1'b0;
    pop         = 1'b0;
    load_fifo   = 1'b0;
    load_bypass = 1'b0;
    clear       = 1'b0;
    if (id_flush) begin
      clear = 1'b1;
    end else if (id_stall) begin
      push = resp_valid;
    end else if (fifo_count != '0) begin
      pop       = 1'b1;
      load_fifo = 1'b1;
      push      = resp_valid;
    end else if (resp_valid) begin
      load_bypass = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= if_pc;
      end
    end
  end

  // With single-cycle memory the fetch issued just before a flush returns
  // in the flush cycle itself and is dropped there, and the fetch issued in
  // the flush cycle is the redirect target, so nothing is ever left to
  // kill. The flag is kept so the discard path is in place if the memory
  // latency grows; it only ever clears when a response returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill <= 1'b0;
    end else if (inflight) begin
      kill <= 1'b0;
    end
  end

  // Storage needs no reset: occupancy and pointers decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= inflight_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Bubbles and flushes keep id_pc and id_misalign so the last real pc
  // stays visible for debug; only valid and the instruction word change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc       <= '0;
      id_instr    <= NOP_INSTR;
      id_valid    <= 1'b0;
      id_misalign <= 1'b0;
    end else if (load_fifo) begin
      id_pc       <= fifo_pc[rd_ptr];
      id_instr    <= fifo_instr[rd_ptr];
      id_valid    <= 1'b1;
      id_misalign <= |fifo_pc[rd_ptr][1:0];
    end else if (load_bypass) begin
      id_pc       <= inflight_pc;
      id_instr    <= imem_rdata;
      id_valid    <= 1'b1;
      id_misalign <= |inflight_pc[1:0];
    end else if (clear || !id_stall) begin
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_if_id_fetch_buffer
//
// Self-checking bench for if_id_fetch_buffer. A directed table covers the
// reset/stream/stall sequence, hand-written sequences cover flush, stall with
// flush, if_ce toggling, misalignment and mid-operation reset, and a random
// phase runs against a queue-based reference model of the fetch buffer.
// ---------------------------------------------------------------------------
module tb_if_id_fetch_buffer;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_ce;
  logic        req_accept;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        id_flush;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        id_misalign;
  logic [1:0]  fifo_count;

  if_id_fetch_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_pc      (if_pc),
    .if_ce      (if_ce),
    .req_accept (req_accept),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_stall   (id_stall),
    .id_flush   (id_flush),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .id_valid   (id_valid),
    .id_misalign(id_misalign),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: buffered instructions are a plain queue; whatever
  // returns from memory joins the back, decode takes from the front.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  bit          m_inflight;
  logic [31:0] m_inflight_pc;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_mis;
  bit          sampled_accept;

  typedef struct {
    bit          ce;
    logic [31:0] pc;
    bit          stall;
    bit          acc;
    bit          valid;
    logic [31:0] opc;
    logic [31:0] oinstr;
    int          cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    check_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    m_inflight    = 1'b0;
    m_inflight_pc = '0;
    m_valid       = 1'b0;
    m_pc          = '0;
    m_instr       = NOP;
    m_mis         = 1'b0;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_valid"}, 32'(id_valid), 32'(m_valid));
    checkOutput({tag, "_pc"}, id_pc, m_pc);
    checkOutput({tag, "_instr"}, id_instr, m_instr);
    checkOutput({tag, "_misalign"}, 32'(id_misalign), 32'(m_mis));
    checkOutput({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
  endtask

  // One clock cycle: drive inputs, check the issue gate, clock, advance the
  // model, then check the IF/ID register and FIFO occupancy.
  task automatic applyStimulus(input bit ce, input logic [31:0] pc,
                               input bit stall, input bit flush);
    logic [31:0] rd;
    bit          exp_acc;
    bit          has_r;
    ent_t        r;
    ent_t        e;
    rd = m_inflight ? m_inflight_pc + 32'h100 : $urandom();
    if_ce      = ce;
    if_pc      = pc;
    id_stall   = stall;
    id_flush   = flush;
    imem_rdata = rd;
    #1;
    exp_acc = ce && ((q.size() + int'(m_inflight)) < DEPTH);
    sampled_accept = req_accept;
    checkOutput("req_accept", 32'(req_accept), 32'(exp_acc));
    checkOutput("imem_en", 32'(imem_en), 32'(exp_acc));
    checkOutput("imem_addr", imem_addr, pc);
    @(posedge clk);
    has_r    = m_inflight;
    r.pc     = m_inflight_pc;
    r.instr  = rd;
    if (flush) begin
      q.delete();
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (stall) begin
      if (has_r) q.push_back(r);
    end else begin
      if (has_r) q.push_back(r);
      if (q.size() > 0) begin
        e       = q.pop_front();
        m_valid = 1'b1;
        m_pc    = e.pc;
        m_instr = e.instr;
        m_mis   = (e.pc[1:0] != 2'b00);
      end else begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
    end
    m_inflight    = exp_acc;
    m_inflight_pc = pc;
    #1;
    checkRegs("cyc");
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    if_ce      = 1'b0;
    if_pc      = '0;
    id_stall   = 1'b0;
    id_flush   = 1'b0;
    imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkRegs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] cur_pc;
    logic [31:0] pc;
    bit          ce;
    bit          st;
    bit          fl;

    tbl[0]  = '{1, 32'h00, 0, 1, 0, 32'h00, NOP,          0};
    tbl[1]  = '{1, 32'h04, 0, 1, 1, 32'h00, 32'h100,      0};
    tbl[2]  = '{1, 32'h08, 0, 1, 1, 32'h04, 32'h104,      0};
    tbl[3]  = '{1, 32'h0C, 0, 1, 1, 32'h08, 32'h108,      0};
    tbl[4]  = '{1, 32'h10, 1, 1, 1, 32'h08, 32'h108,      1};
    tbl[5]  = '{1, 32'h14, 1, 0, 1, 32'h08, 32'h108,      2};
    tbl[6]  = '{1, 32'h14, 1, 0, 1, 32'h08, 32'h108,      2};
    tbl[7]  = '{1, 32'h14, 0, 0, 1, 32'h0C, 32'h10C,      1};
    tbl[8]  = '{1, 32'h14, 0, 1, 1, 32'h10, 32'h110,      0};
    tbl[9]  = '{1, 32'h18, 0, 1, 1, 32'h14, 32'h114,      0};
    tbl[10] = '{0, 32'h18, 0, 0, 1, 32'h18, 32'h118,      0};
    tbl[11] = '{0, 32'h18, 0, 0, 0, 32'h18, NOP,          0};

    doReset();

    // Stream with a three-cycle stall in the middle.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].ce, tbl[i].pc, tbl[i].stall, 1'b0);
      checkOutput($sformatf("tbl%0d_acc", i), 32'(sampled_accept), 32'(tbl[i].acc));
      checkOutput($sformatf("tbl%0d_valid", i), 32'(id_valid), 32'(tbl[i].valid));
      checkOutput($sformatf("tbl%0d_pc", i), id_pc, tbl[i].opc);
      checkOutput($sformatf("tbl%0d_instr", i), id_instr, tbl[i].oinstr);
      checkOutput($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
    end

    // Flush with pc 8 in flight, redirect to 0x40 issued in the flush cycle.
    applyStimulus(1, 32'h00, 0, 0);
    applyStimulus(1, 32'h04, 0, 0);
    applyStimulus(1, 32'h08, 0, 0);
    applyStimulus(1, 32'h40, 0, 1);
    checkOutput("flush_valid", 32'(id_valid), 32'd0);
    checkOutput("flush_instr", id_instr, NOP);
    applyStimulus(0, 32'h40, 0, 0);
    checkOutput("redirect_valid", 32'(id_valid), 32'd1);
    checkOutput("redirect_pc", id_pc, 32'h40);
    checkOutput("redirect_instr", id_instr, 32'h140);
    applyStimulus(0, 32'h40, 0, 0);

    // Stall and flush together with two buffered entries.
    applyStimulus(1, 32'h100, 0, 0);
    applyStimulus(1, 32'h104, 0, 0);
    applyStimulus(1, 32'h108, 1, 0);
    applyStimulus(1, 32'h10C, 1, 0);
    checkOutput("fill_two_count", 32'(fifo_count), 32'd2);
    applyStimulus(1, 32'h10C, 1, 1);
    checkOutput("stall_flush_count", 32'(fifo_count), 32'd0);
    checkOutput("stall_flush_valid", 32'(id_valid), 32'd0);
    applyStimulus(0, 32'h10C, 0, 0);

    // if_ce 1,0,1 gives a bubble between two instructions, then a misaligned pc.
    applyStimulus(1, 32'h80, 0, 0);
    applyStimulus(0, 32'h84, 0, 0);
    checkOutput("toggle_first_pc", id_pc, 32'h80);
    applyStimulus(1, 32'h84, 0, 0);
    checkOutput("toggle_bubble_valid", 32'(id_valid), 32'd0);
    checkOutput("toggle_bubble_instr", id_instr, NOP);
    applyStimulus(1, 32'h06, 0, 0);
    checkOutput("toggle_second_pc", id_pc, 32'h84);
    applyStimulus(0, 32'h06, 0, 0);
    checkOutput("misalign_flag", 32'(id_misalign), 32'd1);
    checkOutput("misalign_instr", id_instr, 32'h106);

    // Reset asserted mid-cycle with two buffered entries.
    applyStimulus(1, 32'h300, 0, 0);
    applyStimulus(1, 32'h304, 1, 0);
    applyStimulus(1, 32'h308, 1, 0);
    checkOutput("pre_reset_count", 32'(fifo_count), 32'd2);
    if_ce = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_accept", 32'(req_accept), 32'd0);
    checkOutput("async_imem_en", 32'(imem_en), 32'd0);
    checkOutput("async_valid", 32'(id_valid), 32'd0);
    checkOutput("async_pc", id_pc, 32'd0);
    checkOutput("async_instr", id_instr, NOP);
    checkOutput("async_misalign", 32'(id_misalign), 32'd0);
    checkOutput("async_count", 32'(fifo_count), 32'd0);
    if_ce = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    modelReset();
    checkRegs("post_reset");
    applyStimulus(1, 32'h200, 0, 0);
    checkOutput("stale_ignored_valid", 32'(id_valid), 32'd0);
    applyStimulus(0, 32'h200, 0, 0);
    checkOutput("after_reset_pc", id_pc, 32'h200);
    checkOutput("after_reset_instr", id_instr, 32'h300);

    // Random traffic against the reference model.
    cur_pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 15) == 0);
      if (fl) cur_pc = {20'h0, $urandom_range(0, 1023), 2'b00};
      pc = cur_pc;
      applyStimulus(ce, pc, st, fl);
      checkOutput("fifo_bound", 32'(fifo_count <= DEPTH), 32'd1);
      if (sampled_accept) begin
        cur_pc = cur_pc + (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd4);
      end
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
